uart_hex_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_echo_queue.sv | 62 ++++++
 rtl/uart_hex_cmd_parser.sv | 181 ++++++++++++++++++
 tb/tb_uart_hex_cmd_parser.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types, character constants and hex helpers for the UART command parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        ERR,
        ISSUE
    } state_t;

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_R_UP = 8'h52;
    localparam logic [7:0] CH_R_LO = 8'h72;
    localparam logic [7:0] CH_QM   = 8'h3F;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    // Letters A-F and a-f share the low nibble 1..6, so adding 9 gives 10..15.
    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39) begin
            return b[3:0];
        end
        return b[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/uart_echo_queue.sv
// Two-entry echo FIFO with uart_tx strobe generation; every CR sent is followed by an LF.
module uart_echo_queue
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_a,
    input  logic [7:0] data_a,
    input  logic       push_b,
    input  logic [7:0] data_b,
    input  logic       echo_ready,
    output logic [7:0] echo_data,
    output logic       echo_write,
    output logic       empty
);

    logic [7:0] mem [2];
    logic [1:0] count;
    logic       rd_ptr;
    logic       wr_ptr;
    logic       lf_pend;
    logic [7:0] head;
    logic       fire;
    logic       pop;

    assign head  = lf_pend ? CH_LF : mem[rd_ptr];
    // Leave one idle cycle after each strobe so a late-falling echo_ready is not double-written.
    assign fire  = echo_ready && !echo_write && (lf_pend || count != 2'd0);
    assign pop   = fire && !lf_pend;
    assign empty = (count == 2'd0) && !lf_pend && !echo_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            lf_pend    <= 1'b0;
            echo_write <= 1'b0;
            echo_data  <= 8'h00;
        end else begin
            echo_write <= fire;
            if (fire) begin
                echo_data <= head;
                if (lf_pend) begin
                    lf_pend <= 1'b0;
                end else begin
                    rd_ptr  <= ~rd_ptr;
                    lf_pend <= (mem[rd_ptr] == CH_CR);
                end
            end
            if (push_a) begin
                mem[wr_ptr] <= data_a;
            end
            if (push_b) begin
                mem[~wr_ptr] <= data_b;
            end
            wr_ptr <= wr_ptr ^ push_a ^ push_b;
            count  <= count + {1'b0, push_a} + {1'b0, push_b} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/uart_hex_cmd_parser.sv
// Parses "R" + 6 hex address digits + optional 1-2 hex length digits + CR into {addr, len} commands.
// Define UART_CMD_ECHO_EN to echo consumed bytes back to uart_tx through uart_echo_queue.
module uart_hex_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] DEFAULT_LEN = 8'd16,
    parameter int         ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_read,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              cmd_ready,
    output logic              cmd_err,
    output logic [7:0]        echo_data,
    output logic              echo_write,
    input  logic              echo_ready
);

    localparam int DIGITS = ADDR_W / 4;
    localparam int ACW    = $clog2(DIGITS + 1);
    localparam logic [ACW-1:0] LAST_DIGIT = ACW'(DIGITS - 1);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        len_n;
    logic [ACW-1:0]    addr_cnt;
    logic [ACW-1:0]    addr_cnt_n;
    logic [1:0]        len_cnt;
    logic [1:0]        len_cnt_n;
    logic              err_n;
    logic              rd_q;
    logic              take;
    logic              echo_ok;
    logic              push_a;
    logic              push_b;
    logic [7:0]        data_a;
    logic [7:0]        data_b;

    // uart_rx drops rx_valid one cycle after rx_read, so never read on back-to-back cycles.
    assign take      = rx_valid && (state != ISSUE) && !rd_q && echo_ok && !rst;
    assign rx_read   = take;
    assign cmd_valid = (state == ISSUE);

`ifdef UART_CMD_ECHO_EN
    logic q_empty;

    uart_echo_queue u_echo (
        .clk        (clk),
        .rst        (rst),
        .push_a     (push_a),
        .data_a     (data_a),
        .push_b     (push_b),
        .data_b     (data_b),
        .echo_ready (echo_ready),
        .echo_data  (echo_data),
        .echo_write (echo_write),
        .empty      (q_empty)
    );

    assign echo_ok = echo_ready && q_empty;
`else
    logic [18:0] unused_echo;

    assign unused_echo = {echo_ready, push_a, push_b, data_a, data_b};
    assign echo_ok     = 1'b1;
    assign echo_write  = 1'b0;
    assign echo_data   = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd_addr <= '0;
            cmd_len  <= 8'h00;
            addr_cnt <= '0;
            len_cnt  <= 2'd0;
            cmd_err  <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cmd_addr <= addr_n;
            cmd_len  <= len_n;
            addr_cnt <= addr_cnt_n;
            len_cnt  <= len_cnt_n;
            cmd_err  <= err_n;
            rd_q     <= take;
        end
    end

    // A line rejected at its CR echoes "?" + CR; the queue appends the LF.
    always_comb begin
        state_n    = state;
        addr_n     = cmd_addr;
        len_n      = cmd_len;
        addr_cnt_n = addr_cnt;
        len_cnt_n  = len_cnt;
        err_n      = 1'b0;
        push_a     = take;
        push_b     = 1'b0;
        data_a     = rx_data;
        data_b     = CH_CR;
        if (take) begin
            case (state)
                IDLE: begin
                    if (rx_data == CH_R_UP || rx_data == CH_R_LO) begin
                        state_n    = ADDR;
                        addr_n     = '0;
                        addr_cnt_n = '0;
                    end else if (rx_data != CH_CR && rx_data != CH_LF) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                ADDR: begin
                    if (is_hex(rx_data)) begin
                        addr_n = {cmd_addr[ADDR_W-5:0], hex_val(rx_data)};
                        if (addr_cnt == LAST_DIGIT) begin
                            state_n   = LEN;
                            len_n     = 8'h00;
                            len_cnt_n = 2'd0;
                        end else begin
                            addr_cnt_n = addr_cnt + 1'b1;
                        end
                    end else if (rx_data == CH_CR) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        data_a  = CH_QM;
                        push_b  = 1'b1;
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                LEN: begin
                    if (is_hex(rx_data)) begin
                        if (len_cnt == 2'd2) begin
                            state_n = ERR;
                            err_n   = 1'b1;
                        end else begin
                            len_n     = {cmd_len[3:0], hex_val(rx_data)};
                            len_cnt_n = len_cnt + 1'b1;
                        end
                    end else if (rx_data == CH_CR) begin
                        if (len_cnt == 2'd0) begin
                            state_n = ISSUE;
                            len_n   = DEFAULT_LEN;
                        end else if (cmd_len != 8'h00) begin
                            state_n = ISSUE;
                        end else begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                            data_a  = CH_QM;
                            push_b  = 1'b1;
                        end
                    end else begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
                ERR: begin
                    if (rx_data == CH_CR) begin
                        state_n = IDLE;
                        data_a  = CH_QM;
                        push_b  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end else if (state == ISSUE && cmd_ready) begin
            state_n = IDLE;
        end
    end

endmodule

// File: tb/tb_uart_hex_cmd_parser.sv
// Directed self-checking bench for uart_hex_cmd_parser; echo checks run when UART_CMD_ECHO_EN is defined.
module tb_uart_hex_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_read;
    logic        cmd_valid;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_ready = 1'b1;
    logic        cmd_err;
    logic [7:0]  echo_data;
    logic        echo_write;
    logic        echo_ready = 1'b1;
    logic        echo_toggle = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_read = 0;
    int n_sent = 0;
    int n_err = 0;
    int n_cmd = 0;
    int n_echo = 0;
    int valid_hi = 0;
    int rise_cyc = 0;
    int last_read_cyc = 0;
    int viol_errvalid = 0;
    int viol_errerr = 0;
    int viol_echo_gate = 0;
    logic        prev_err = 1'b0;
    logic        prev_valid = 1'b0;
    logic [23:0] got_addr = '0;
    logic [7:0]  got_len = '0;
    logic [7:0]  echo_log [$];

    int e0;
    int r0;
    int v0;
    int c0;

    always #5 clk = ~clk;

    uart_hex_cmd_parser dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_read    (rx_read),
        .cmd_valid  (cmd_valid),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .cmd_err    (cmd_err),
        .echo_data  (echo_data),
        .echo_write (echo_write),
        .echo_ready (echo_ready)
    );

    always @(negedge clk) begin
        echo_ready = echo_toggle ? ~echo_ready : 1'b1;
    end

    // Observe outputs mid-cycle, well clear of the rising edge.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (rx_read === 1'b1) begin
            n_read++;
            last_read_cyc = cyc;
            if (echo_ready !== 1'b1) viol_echo_gate++;
        end
        if (cmd_err === 1'b1) begin
            n_err++;
            if (cmd_valid === 1'b1) viol_errvalid++;
            if (prev_err === 1'b1) viol_errerr++;
        end
        prev_err = cmd_err;
        if (cmd_valid === 1'b1) begin
            valid_hi++;
            if (prev_valid !== 1'b1) rise_cyc = cyc;
            if (cmd_ready === 1'b1) begin
                n_cmd++;
                got_addr = cmd_addr;
                got_len  = cmd_len;
            end
        end
        prev_valid = cmd_valid;
        if (echo_write === 1'b1) begin
            n_echo++;
            echo_log.push_back(echo_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        n_sent++;
        #1;
        while (rx_read !== 1'b1 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rx_read !== 1'b1) checkOutput("rx_read_timeout", 32'd0, 32'd1);
        idle(2);
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input string s, input bit add_cr);
        for (int i = 0; i < s.len(); i++) sendByte(s[i]);
        if (add_cr) sendByte(8'h0D);
    endtask

    task automatic waitCmd(input int target);
        int n;
        n = 0;
        while (n_cmd < target && n < 400) begin
            @(negedge clk);
            #3;
            n++;
        end
        checkOutput("cmd_count", n_cmd, target);
    endtask

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_echo [9];

        // Reset state, with a byte offered while reset is held.
        rx_data  = 8'h0D;
        rx_valid = 1'b1;
        idle(3);
        #1;
        checkOutput("rst_rx_read", rx_read, 1'b0);
        checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
        checkOutput("rst_cmd_addr", cmd_addr, 24'h0);
        checkOutput("rst_cmd_len", cmd_len, 8'h0);
        checkOutput("rst_cmd_err", cmd_err, 1'b0);
        checkOutput("rst_echo_write", echo_write, 1'b0);
        checkOutput("rst_echo_data", echo_data, 8'h0);
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Basic command with default length.
        $display("[TB] basic R400000");
        e0 = n_err; r0 = n_read; v0 = valid_hi;
        applyStimulus("R400000", 1'b1);
        waitCmd(1);
        idle(2);
        checkOutput("t1_addr", got_addr, 24'h400000);
        checkOutput("t1_len", got_len, 8'd16);
        checkOutput("t1_reads", n_read - r0, 8);
        checkOutput("t1_err", n_err - e0, 0);
        checkOutput("t1_latency", rise_cyc - last_read_cyc, 1);
        checkOutput("t1_valid_cycles", valid_hi - v0, 1);

        // Back-pressure holds the command and blocks further bytes.
        $display("[TB] back-pressure r40001a1F");
        cmd_ready = 1'b0;
        applyStimulus("r40001a1F", 1'b1);
        idle(3);
        checkOutput("t2_valid", cmd_valid, 1'b1);
        checkOutput("t2_addr_hold", cmd_addr, 24'h40001A);
        checkOutput("t2_len_hold", cmd_len, 8'h1F);
        r0 = n_read;
        rx_data  = 8'h52;
        rx_valid = 1'b1;
        idle(50);
        checkOutput("t2_held_off", n_read - r0, 0);
        checkOutput("t2_valid_after_50", cmd_valid, 1'b1);
        cmd_ready = 1'b1;
        #3;
        checkOutput("t2_cmd_count", n_cmd, 2);
        checkOutput("t2_addr", got_addr, 24'h40001A);
        checkOutput("t2_len", got_len, 8'h1F);
        applyStimulus("R000000", 1'b1);
        waitCmd(3);
        checkOutput("t2b_addr", got_addr, 24'h000000);
        checkOutput("t2b_len", got_len, 8'd16);

        // Three malformed lines.
        $display("[TB] malformed lines");
        e0 = n_err; c0 = n_cmd;
        applyStimulus("R4000", 1'b1);
        idle(2);
        checkOutput("t3_short_addr", n_err - e0, 1);
        applyStimulus("R400000123", 1'b1);
        idle(2);
        checkOutput("t3_long_len", n_err - e0, 2);
        applyStimulus("R40000000", 1'b1);
        idle(2);
        checkOutput("t3_zero_len", n_err - e0, 3);
        checkOutput("t3_no_cmd", n_cmd, c0);

        // Stray LF is ignored, a garbage line errors once, then recovery.
        $display("[TB] garbage then recovery");
        e0 = n_err;
        sendByte(8'h0A);
        idle(2);
        checkOutput("t4_lf_ignored", n_err - e0, 0);
        applyStimulus("X123", 1'b1);
        idle(2);
        checkOutput("t4_err", n_err - e0, 1);
        applyStimulus("R000010", 1'b1);
        waitCmd(c0 + 1);
        checkOutput("t4_addr", got_addr, 24'h000010);
        checkOutput("t4_len", got_len, 8'd16);

        // Reset mid-line discards the partial address.
        $display("[TB] reset mid-line");
        applyStimulus("R40", 1'b0);
        rst = 1'b1;
        idle(2);
        checkOutput("t5_addr_cleared", cmd_addr, 24'h0);
        rst = 1'b0;
        idle(1);
        e0 = n_err; c0 = n_cmd;
        applyStimulus("00000", 1'b1);
        idle(2);
        checkOutput("t5_err", n_err - e0, 1);
        applyStimulus("R400000", 1'b1);
        waitCmd(c0 + 1);
        checkOutput("t5_addr", got_addr, 24'h400000);
        checkOutput("t5_len", got_len, 8'd16);

        // Single length digit and maximum length, mixed-case hex.
        $display("[TB] length boundaries");
        applyStimulus("Rabcdef9", 1'b1);
        waitCmd(c0 + 2);
        checkOutput("t6_addr", got_addr, 24'hABCDEF);
        checkOutput("t6_len_one_digit", got_len, 8'h09);
        applyStimulus("r00000AfF", 1'b1);
        waitCmd(c0 + 3);
        checkOutput("t7_addr", got_addr, 24'h00000A);
        checkOutput("t7_len_max", got_len, 8'hFF);

`ifdef UART_CMD_ECHO_EN
        $display("[TB] echo with echo_ready toggling");
        idle(20);
        echo_log.delete();
        echo_toggle = 1'b1;
        c0 = n_cmd;
        applyStimulus("R400000", 1'b1);
        waitCmd(c0 + 1);
        idle(30);
        echo_toggle = 1'b0;
        exp_echo = '{8'h52, 8'h34, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        checkOutput("echo_count", echo_log.size(), 9);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("echo_byte%0d", i), (i < echo_log.size()) ? echo_log[i] : 8'hXX, exp_echo[i]);
        end
        checkOutput("echo_gate", viol_echo_gate, 0);
`else
        checkOutput("no_echo_writes", n_echo, 0);
`endif

        idle(5);
        checkOutput("err_with_valid", viol_errvalid, 0);
        checkOutput("err_back_to_back", viol_errerr, 0);
        checkOutput("reads_per_byte", n_read, n_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
